// File: rtl/clk_cen_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_cen_gen : multi-channel fractional clock-enable generator (phase accum.)
// Rev 1.0
// ---------------------------------------------------------------------------
module clk_cen_gen #(
  parameter int                      NUM_CH      = 3,
  parameter int                      ACC_W       = 24,
  parameter int                      LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = '0
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] cen,
  output logic              locked
);

  localparam int               CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]       CH_LIM   = 4'(NUM_CH);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, ch_ok, apply_go, live;
  logic [2:0]       ch_lat;
  logic [ACC_W-1:0] inc_lat;
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cfg_ready = (state_q != ST_APPLY);
    locked    = (state_q == ST_LOCKED);
    accept    = cfg_valid & cfg_ready;
    ch_ok     = ({1'b0, cfg_ch} < CH_LIM);
    apply_go  = accept & ch_ok;
    state_d   = state_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_LOCKED;
      end
      ST_LOCKED: state_d = ST_LOCKED;
      ST_APPLY: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      default: state_d = ST_SETTLE;
    endcase
    if (apply_go) begin
      state_d = ST_APPLY;
      cnt_d   = '0;
    end
    // Gating on the next state too keeps any pulse from outliving locked.
    live = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
      end
      cen     <= '0;
      cfg_err <= 1'b0;
      ch_lat  <= '0;
      inc_lat <= '0;
    end else begin
      cfg_err <= accept & ~ch_ok;
      if (accept) begin
        ch_lat  <= cfg_ch;
        inc_lat <= cfg_inc;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (state_q == ST_APPLY) begin
          acc[i] <= '0;
          cen[i] <= 1'b0;
          if (ch_lat == 3'(i)) inc[i] <= inc_lat;
        end else if (sync_req && !apply_go) begin
          acc[i] <= '0;
          cen[i] <= 1'b0;
        end else begin
          acc[i] <= sum[i][ACC_W-1:0];
          cen[i] <= sum[i][ACC_W] & live;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/clk_cen_gen.md
Name: clk_cen_gen

Overview:
- Multi-channel fractional clock-enable generator. Derives NUM_CH independent enable pulse trains from the single PLL output clock; typical loads are the NES master, PPU and CPU enables from the 21 MHz clock.
- Replaces fixed-ratio dividers with per-channel phase accumulators, each programmable at run time over a valid/ready config port.
- Provides a `locked` indication that mirrors PLL-lock semantics. Downstream logic must hold off until `locked` is high.

Parameters:
- NUM_CH, 3, number of enable channels (1..8).
- ACC_W, 24, phase accumulator and increment width in bits (8..32).
- LOCK_CYCLES, 16, number of settle cycles after reset or reconfiguration before `locked` asserts (≥2).
- INIT_INC, {NUM_CH{24'h0}}, packed per-channel reset increments; channel i occupies bits [i*ACC_W +: ACC_W].

Ports:
- refclk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config port can accept a request.
- cfg_ch  in  3  target channel index.
- cfg_inc  in  ACC_W  new increment for the target channel.
- cfg_err  out  1  one-cycle pulse when a request is accepted with cfg_ch ≥ NUM_CH.
- sync_req  in  1  single-cycle request to realign all channel phases.
- cen  out  NUM_CH  per-channel enable pulses, one refclk cycle wide.
- locked  out  1  outputs are valid and stable.

Behaviour:
- Reset (rst=1 at an edge):
  - acc[i]=0; inc[i]=INIT_INC slice; state=SETTLE; settle counter=0.
  - cen=0, locked=0, cfg_ready=1, cfg_err=0.
  - rst overrides every other input, including mid-APPLY or mid-SETTLE.
- Accumulator update, every cycle outside reset and APPLY:
  - {carry[i], acc[i]} <= acc[i] + inc[i], computed at ACC_W+1 bits.
  - Registered cen[i] <= carry[i] & (state==LOCKED). A pulse therefore appears the cycle after the overflowing add.
  - Pulse rate is f_refclk·inc/2^ACC_W. inc=0 never fires. inc=2^ACC_W−1 fires on all but one cycle in 2^ACC_W.
  - Wrap-around is modular: the residue is kept, so long-run rate is exact.
- FSM, states SETTLE, LOCKED, APPLY:
  - SETTLE:
    - Counter increments each cycle; accumulators run; cen is forced 0.
    - When counter==LOCK_CYCLES−1, go to LOCKED.
  - LOCKED:
    - Set locked=1 (registered, i.e. locked is exactly state==LOCKED).
    - cen is live.
  - APPLY (exactly 1 cycle):
    - Write inc[cfg_ch_latched].
    - Clear all acc to 0; cen=0.
    - Go to SETTLE with counter=0; locked=0 from this cycle onward.
- Config handshake:
  - cfg_ready = (state != APPLY).
  - A request is accepted on an edge with cfg_valid & cfg_ready. cfg_ch and cfg_inc are latched on acceptance.
  - Valid cfg_ch: next state is APPLY.
  - cfg_ch ≥ NUM_CH: no write, no state change, lock is kept; cfg_err=1 the next cycle.
  - Accepting in SETTLE is allowed and restarts the settle sequence via APPLY.
  - Values on cfg_ch/cfg_inc while not accepted are ignored.
- sync_req:
  - In SETTLE or LOCKED, the next edge sets all acc to 0 instead of the add. inc is unchanged; locked is unchanged; cen=0 that cycle.
  - Ignored during APPLY.
  - sync_req coincident with a valid config accept: the config wins. APPLY clears acc anyway, so no double action occurs.
- Lock-loss ordering: locked drops in the same cycle that cen is forced low. No partial pulse can follow a locked deassertion.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0 → cen=0, cfg_ready=1. locked=0 for exactly 16 cycles after the first edge with rst=0, then 1 and held.
- Divide-by-4: INIT_INC ch0=24'h400000, after lock plus sync_req → cen[0] pulses 1 cycle in every 4, first pulse on the 5th edge after sync_req. Count 100 pulses in 400 cycles.
- Fractional rate: ch1 cfg_inc=24'h155555 (≈1/12) → over 12·2^20 cycles, pulse count is within ±1 of 2^20. Pulse spacing is always 12 or 13 cycles.
- Reconfig: while locked, cfg_valid ch2 inc=24'h800000 → accepted while cfg_ready=1, then cfg_ready=0 for 1 cycle. locked=0 for 17 cycles, then cen[2] pulses every 2 cycles.
- Error path: cfg_ch=5 with NUM_CH=3 → cfg_err pulse next cycle, locked stays 1, all cen sequences unchanged.
- Reset mid-settle: issue a valid config, assert rst 5 cycles into SETTLE → all inc back to INIT_INC, acc=0, and lock reacquired 16 cycles after rst falls.
